// File: rtl/smol_fetch_ctrl.sv
// Instruction-fetch controller for a synchronous-read ROM: owns the fetch PC, tracks the
// single in-flight read and buffers returned words in a 2-entry skid FIFO for decode.
// Optional: define SMOL_FETCH_MISALIGN_CHK_EN to trap misaligned redirects in a sticky ERR state.

module smol_fetch_ctrl #(
   parameter int unsigned          ADDR_WIDTH = 10,
   parameter int unsigned          DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH+1:0] RESET_PC  = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH+1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH+1:0] redirect_pc,
   input  logic                  halt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [ADDR_WIDTH+1:0] out_pc,
   output logic                  fetch_err
);

   localparam int unsigned PC_W = ADDR_WIDTH + 2;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_HALTED = 2'd1;
`ifdef SMOL_FETCH_MISALIGN_CHK_EN
   localparam logic [1:0] ST_ERR    = 2'd2;
`endif

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [PC_W-1:0]       fetch_pc;
   logic [PC_W-1:0]       fetch_pc_nxt;
   logic                  infl;
   logic                  infl_nxt;
   logic [PC_W-1:0]       infl_pc;
   logic [PC_W-1:0]       infl_pc_nxt;
   logic [1:0]            count;
   logic [1:0]            count_nxt;
   logic [DATA_WIDTH-1:0] head_instr_nxt;
   logic [PC_W-1:0]       head_pc_nxt;
   logic [DATA_WIDTH-1:0] tail_instr;
   logic [DATA_WIDTH-1:0] tail_instr_nxt;
   logic [PC_W-1:0]       tail_pc;
   logic [PC_W-1:0]       tail_pc_nxt;
   logic [2:0]            occupancy;
   logic                  in_err;
   logic                  pop;
   logic                  push;
   logic                  flush;
   logic                  issue;
   logic                  err_set;

   assign imem_addr = fetch_pc;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus the per-cycle control decisions (flush / push / issue)
   always_comb begin
      state_nxt = state;
      flush     = 1'b0;
      push      = 1'b0;
      issue     = 1'b0;
      err_set   = 1'b0;
      pop       = out_valid && out_ready;
      // words held or still arriving after this cycle's pop
      occupancy = 3'(count) + 3'(infl) - 3'(pop);

      if (!in_err) begin
         if (redirect_valid) begin
            flush = 1'b1;
`ifdef SMOL_FETCH_MISALIGN_CHK_EN
            if (redirect_pc[1:0] != 2'b00) begin
               err_set   = 1'b1;
               state_nxt = ST_ERR;
            end
`endif
         end else begin
            push  = infl;
            issue = (state == ST_RUN) && !halt && (occupancy < 3'd2);
            case (state)
               ST_RUN: begin
                  if (halt) begin
                     state_nxt = ST_HALTED;
                  end
               end
               ST_HALTED: begin
                  if (!halt) begin
                     state_nxt = ST_RUN;
                  end
               end
               default: begin
                  state_nxt = state;
               end
            endcase
         end
      end
   end

   // Fetch PC and in-flight tracking
   always_comb begin
      fetch_pc_nxt = fetch_pc;
      infl_nxt     = issue;
      infl_pc_nxt  = infl_pc;
      if (issue) begin
         infl_pc_nxt  = fetch_pc;
         fetch_pc_nxt = fetch_pc + PC_W'(4);
      end else if (flush && !err_set) begin
         fetch_pc_nxt = {redirect_pc[PC_W-1:2], 2'b00};
      end
   end

   // Skid FIFO: head lives in out_instr/out_pc, second entry in tail_*
   always_comb begin
      count_nxt      = count;
      head_instr_nxt = out_instr;
      head_pc_nxt    = out_pc;
      tail_instr_nxt = tail_instr;
      tail_pc_nxt    = tail_pc;

      if (flush) begin
         count_nxt = 2'd0;
      end else if (!in_err) begin
         count_nxt = count + 2'(push) - 2'(pop);
         if (pop) begin
            head_instr_nxt = tail_instr;
            head_pc_nxt    = tail_pc;
         end
         if (push) begin
            if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
               head_instr_nxt = imem_rdata;
               head_pc_nxt    = infl_pc;
            end else begin
               tail_instr_nxt = imem_rdata;
               tail_pc_nxt    = infl_pc;
            end
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc   <= RESET_PC;
         infl       <= 1'b0;
         infl_pc    <= '0;
         count      <= 2'd0;
         out_valid  <= 1'b0;
         out_instr  <= '0;
         out_pc     <= '0;
         tail_instr <= '0;
         tail_pc    <= '0;
      end else begin
         fetch_pc   <= fetch_pc_nxt;
         infl       <= infl_nxt;
         infl_pc    <= infl_pc_nxt;
         count      <= count_nxt;
         out_valid  <= (count_nxt != 2'd0);
         out_instr  <= head_instr_nxt;
         out_pc     <= head_pc_nxt;
         tail_instr <= tail_instr_nxt;
         tail_pc    <= tail_pc_nxt;
      end
   end

`ifdef SMOL_FETCH_MISALIGN_CHK_EN
   assign in_err = (state == ST_ERR);

   // Sticky until reset, like the ERR state itself
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_err <= 1'b0;
      end else if (err_set) begin
         fetch_err <= 1'b1;
      end
   end
`else
   logic unused_pc_lsb;

   assign in_err        = 1'b0;
   assign fetch_err     = 1'b0;
   // low redirect bits are dropped when the alignment trap is not built
   assign unused_pc_lsb = ^redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_smol_fetch_ctrl.sv
// Self-checking bench for smol_fetch_ctrl: directed vector table, hand-written corner
// sequences and a randomized run checked against a queue-based behavioural model.

module tb_smol_fetch_ctrl;

   localparam int unsigned AW   = 10;
   localparam int unsigned DW   = 32;
   localparam int unsigned PW   = AW + 2;
   localparam int unsigned AW_S = 4;
   localparam int unsigned PW_S = AW_S + 2;

`ifdef SMOL_FETCH_MISALIGN_CHK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [PW-1:0] imem_addr;
   logic [DW-1:0] imem_rdata;
   logic          redirect_valid;
   logic [PW-1:0] redirect_pc;
   logic          halt;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_instr;
   logic [PW-1:0] out_pc;
   logic          fetch_err;

   logic [PW_S-1:0] s_addr;
   logic [DW-1:0]   s_rdata;
   logic            s_rv;
   logic [PW_S-1:0] s_rpc;
   logic            s_halt;
   logic            s_valid;
   logic            s_ready;
   logic [DW-1:0]   s_instr;
   logic [PW_S-1:0] s_pc;
   logic            s_err;

   always #5 clk = ~clk;

   smol_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .fetch_err(fetch_err)
   );

   // Narrow instance used only to observe PC wrap-around
   smol_fetch_ctrl #(.ADDR_WIDTH(AW_S), .DATA_WIDTH(DW)) dut_s (
      .clk(clk), .rst_n(rst_n), .imem_addr(s_addr), .imem_rdata(s_rdata),
      .redirect_valid(s_rv), .redirect_pc(s_rpc), .halt(s_halt),
      .out_valid(s_valid), .out_ready(s_ready), .out_instr(s_instr),
      .out_pc(s_pc), .fetch_err(s_err)
   );

   // Synchronous-read ROMs holding word[i] = i
   always @(posedge clk) begin
      imem_rdata <= DW'(imem_addr >> 2);
      s_rdata    <= DW'(s_addr >> 2);
   end

   int checks = 0;
   int errors = 0;

   // Reference model: queue of PCs visible to decode, optional in-flight PC, mode
   int q_pc[$];
   bit m_infl;
   int m_infl_pc;
   int m_pc;
   int m_mode;   // 0 running, 1 halted, 2 trapped on misaligned redirect
   bit m_err;

   typedef struct {
      bit          ready;
      bit          valid;
      logic [11:0] pc;
      logic [11:0] addr;
      logic [31:0] instr;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_step(input bit rd, input bit hl, input bit rv, input int rp, input bit rs);
      bit pop;
      bit go;
      int held;
      if (!rs) begin
         q_pc.delete();
         m_infl = 1'b0;
         m_pc   = 0;
         m_mode = 0;
         m_err  = 1'b0;
      end else if (m_mode != 2) begin
         if (rv) begin
            q_pc.delete();
            m_infl = 1'b0;
            if (CHK_EN && (rp % 4 != 0)) begin
               m_mode = 2;
               m_err  = 1'b1;
            end else begin
               m_pc = rp - (rp % 4);
            end
         end else begin
            pop  = (q_pc.size() != 0) && rd;
            held = q_pc.size() + int'(m_infl) - int'(pop);
            go   = (m_mode == 0) && !hl && (held < 2);
            if (pop) void'(q_pc.pop_front());
            if (m_infl) q_pc.push_back(m_infl_pc);
            m_infl = go;
            if (go) begin
               m_infl_pc = m_pc;
               m_pc      = (m_pc + 4) % 4096;
            end
            if (m_mode == 0 && hl) m_mode = 1;
            else if (m_mode == 1 && !hl) m_mode = 0;
         end
      end
   endtask

   task automatic check_model();
      chk("valid", 64'(out_valid), 64'(q_pc.size() != 0));
      chk("imem_addr", 64'(imem_addr), 64'(m_pc));
      chk("fetch_err", 64'(fetch_err), 64'(m_err));
      if (q_pc.size() != 0) begin
         chk("out_pc", 64'(out_pc), 64'(q_pc[0]));
         chk("out_instr", 64'(out_instr), 64'(q_pc[0] / 4));
      end
   endtask

   // Drive one cycle of inputs, advance the model, then compare after the edge
   task automatic tick(input bit rd, input bit hl, input bit rv, input int rp, input bit rs);
      out_ready      = rd;
      halt           = hl;
      redirect_valid = rv;
      redirect_pc    = PW'(rp);
      rst_n          = rs;
      model_step(rd, hl, rv, rp, rs);
      @(negedge clk);
      check_model();
   endtask

   initial begin
      int n;
      int rp;
      bit hl_lvl;
      bit rd;
      bit rv;
      bit rs;

      tbl[0]  = '{1'b1, 1'b0, 12'h000, 12'h000, 32'd0};
      tbl[1]  = '{1'b1, 1'b0, 12'h000, 12'h004, 32'd0};
      tbl[2]  = '{1'b1, 1'b1, 12'h000, 12'h008, 32'd0};
      tbl[3]  = '{1'b1, 1'b1, 12'h004, 12'h00C, 32'd1};
      tbl[4]  = '{1'b1, 1'b1, 12'h008, 12'h010, 32'd2};
      tbl[5]  = '{1'b0, 1'b1, 12'h00C, 12'h014, 32'd3};
      tbl[6]  = '{1'b0, 1'b1, 12'h00C, 12'h014, 32'd3};
      tbl[7]  = '{1'b0, 1'b1, 12'h00C, 12'h014, 32'd3};
      tbl[8]  = '{1'b0, 1'b1, 12'h00C, 12'h014, 32'd3};
      tbl[9]  = '{1'b0, 1'b1, 12'h00C, 12'h014, 32'd3};
      tbl[10] = '{1'b1, 1'b1, 12'h00C, 12'h014, 32'd3};
      tbl[11] = '{1'b1, 1'b1, 12'h010, 12'h018, 32'd4};
      tbl[12] = '{1'b1, 1'b1, 12'h014, 12'h01C, 32'd5};
      tbl[13] = '{1'b1, 1'b1, 12'h018, 12'h020, 32'd6};

      out_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; rst_n = 1'b0;
      s_ready = 1'b1; s_halt = 1'b0; s_rv = 1'b0; s_rpc = '0;
      @(negedge clk);
      repeat (3) tick(1, 0, 0, 0, 0);

      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_addr", 64'(imem_addr), 64'd0);
      chk("rst_err", 64'(fetch_err), 64'd0);
      chk("rst_pc", 64'(out_pc), 64'd0);
      chk("rst_instr", 64'(out_instr), 64'd0);

      // Narrow instance: sequential stream must wrap from 0x3C to 0x00
      for (int c = 0; c < 24; c++) begin
         chk("wrap_addr", 64'(s_addr), 64'((4 * c) % 64));
         chk("wrap_valid", 64'(s_valid), 64'(c >= 2));
         if (c >= 2) begin
            chk("wrap_pc", 64'(s_pc), 64'((4 * (c - 2)) % 64));
            chk("wrap_instr", 64'(s_instr), 64'(((4 * (c - 2)) % 64) / 4));
         end
         tick(1, 0, 0, 0, 1);
      end

      // Directed table: start-up latency, streaming, 5-cycle backpressure
      repeat (2) tick(1, 0, 0, 0, 0);
      for (int i = 0; i < 14; i++) begin
         chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].valid));
         chk($sformatf("tbl%0d_pc", i), 64'(out_pc), 64'(tbl[i].pc));
         chk($sformatf("tbl%0d_addr", i), 64'(imem_addr), 64'(tbl[i].addr));
         chk($sformatf("tbl%0d_instr", i), 64'(out_instr), 64'(tbl[i].instr));
         tick(tbl[i].ready, 0, 0, 0, 1);
      end

      // Redirect to 0x100 with the FIFO full
      repeat (3) tick(0, 0, 0, 0, 1);
      tick(0, 0, 1, 'h100, 1);
      chk("redir_valid_r1", 64'(out_valid), 64'd0);
      chk("redir_addr_r1", 64'(imem_addr), 64'h100);
      tick(1, 0, 0, 0, 1);
      chk("redir_valid_r2", 64'(out_valid), 64'd0);
      tick(1, 0, 0, 0, 1);
      chk("redir_valid_r3", 64'(out_valid), 64'd1);
      chk("redir_pc_r3", 64'(out_pc), 64'h100);
      chk("redir_instr_r3", 64'(out_instr), 64'h40);
      repeat (3) tick(1, 0, 0, 0, 1);
      chk("pre_halt_pc", 64'(out_pc), 64'h10C);
      chk("pre_halt_addr", 64'(imem_addr), 64'h114);

      // Halt for 4 cycles: buffered words drain, then nothing
      for (int k = 1; k <= 4; k++) begin
         tick(1, 1, 0, 0, 1);
         chk($sformatf("halt%0d_valid", k), 64'(out_valid), 64'(k == 1));
         if (k == 1) chk("halt_drain_pc", 64'(out_pc), 64'h110);
      end
      n = 0;
      while (!out_valid && n < 8) begin
         tick(1, 0, 0, 0, 1);
         n++;
      end
      chk("halt_resume_lat", 64'(n), 64'd3);
      chk("halt_resume_pc", 64'(out_pc), 64'h114);
      chk("halt_resume_instr", 64'(out_instr), 64'h45);

      // Reset with buffered words: discarded, pc 0 refetched
      repeat (3) tick(0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0);
      chk("mrst_valid", 64'(out_valid), 64'd0);
      chk("mrst_addr", 64'(imem_addr), 64'd0);
      tick(1, 0, 0, 0, 1);
      tick(1, 0, 0, 0, 1);
      chk("mrst_refetch_valid", 64'(out_valid), 64'd1);
      chk("mrst_refetch_pc", 64'(out_pc), 64'd0);

      // Misaligned redirect to 0x102
      repeat (2) tick(1, 0, 0, 0, 1);
      tick(1, 0, 1, 'h102, 1);
      chk("mis_valid", 64'(out_valid), 64'd0);
`ifdef SMOL_FETCH_MISALIGN_CHK_EN
      chk("mis_err", 64'(fetch_err), 64'd1);
      for (int i = 0; i < 8; i++) begin
         tick(1, i[0], (i == 3), 'h200, 1);
         chk("mis_err_sticky", 64'(fetch_err), 64'd1);
         chk("mis_no_valid", 64'(out_valid), 64'd0);
      end
      tick(1, 0, 0, 0, 0);
      chk("mis_err_cleared", 64'(fetch_err), 64'd0);
`else
      chk("mis_err_off", 64'(fetch_err), 64'd0);
      chk("mis_addr_aligned", 64'(imem_addr), 64'h100);
      repeat (2) tick(1, 0, 0, 0, 1);
      chk("mis_pc_aligned", 64'(out_pc), 64'h100);
`endif

      // Randomized traffic against the model
      hl_lvl = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0) hl_lvl = !hl_lvl;
         rd = ($urandom_range(0, 3) != 0);
         rv = ($urandom_range(0, 19) == 0);
         rp = int'($urandom_range(0, 4095));
         if (CHK_EN && $urandom_range(0, 7) != 0) rp = rp - (rp % 4);
         rs = ($urandom_range(0, 99) != 0) || (i == 0);
         tick(rd, hl_lvl, rv, rp, rs);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      errors++;
      $display("FAIL watchdog at %0t: got timeout, expected completion", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
